// File: rtl/microcode_bootstrap.sv
// -----------------------------------------------------------------------------
// microcode_bootstrap
//
// After reset, copies the microcode image from an external byte-wide boot ROM
// into the control logic's microcode store through its bootstrap port. The
// rest of the CPU is held in reset until the image is loaded. Afterwards the
// store is switched to read mode (N_BOOTED low) and the loader stays idle
// until the next reset.
//
// Per byte: LOAD (1) + WAIT (ROM_WAIT) + WRITE (1) + HOLD (1) cycles. The very
// first LOAD after reset takes one extra cycle to present address 0 with the
// ROM output enabled, because address and enable are registered.
//
// Optional feature (compile-time macro BOOTSTRAP_CHECKSUM_EN):
//   After the last byte, ROM address COUNT is read as a check byte. The 8-bit
//   sum of all image bytes plus the check byte must be zero; otherwise the
//   loader stops in ERROR with BOOT_ERR high and the CPU held in reset.
//   COUNT must then be at most 4095. Without the macro BOOT_ERR is tied low.
//
// Parameters:
//   COUNT    : bytes to copy, 1..4096 (ROM addresses 0..COUNT-1)
//   ROM_WAIT : ROM access wait cycles, 1..15
//
// Ports:
//   CLK            in   system clock, rising edge
//   N_RST          in   asynchronous active-low reset
//   ROM_ADDR       out  [11:0] boot ROM address
//   ROM_N_OE       out  boot ROM output enable, active-low
//   ROM_DATA       in   [7:0] boot ROM data
//   BOOTSTRAP_ADDR out  [11:0] microcode store write address
//   BOOTSTRAP_DATA out  [7:0]  microcode store write data
//   BOOTSTRAP_N_WE out  microcode store write strobe, active-low
//   N_BOOTED       out  low once the image is loaded
//   SYS_N_RST      out  reset for the rest of the CPU, active-low
//   BOOT_ERR       out  checksum failure flag
// -----------------------------------------------------------------------------
module microcode_bootstrap #(
  parameter int COUNT    = 4096,
  parameter int ROM_WAIT = 2
) (
  input  logic        CLK,
  input  logic        N_RST,
  output logic [11:0] ROM_ADDR,
  output logic        ROM_N_OE,
  input  logic [7:0]  ROM_DATA,
  output logic [11:0] BOOTSTRAP_ADDR,
  output logic [7:0]  BOOTSTRAP_DATA,
  output logic        BOOTSTRAP_N_WE,
  output logic        N_BOOTED,
  output logic        SYS_N_RST,
  output logic        BOOT_ERR
);

`ifdef BOOTSTRAP_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_LOAD, S_WAIT, S_WRITE, S_HOLD, S_CHECK, S_DONE, S_ERROR
  } state_e;
`else
  typedef enum logic [2:0] {
    S_LOAD, S_WAIT, S_WRITE, S_HOLD, S_DONE
  } state_e;
`endif

  localparam logic [11:0] LAST_IDX  = 12'(COUNT - 1);
  localparam logic [3:0]  WAIT_LOAD = 4'(ROM_WAIT);

  state_e      state_q;
  logic [11:0] idx_q;
  logic [11:0] idx_d;
  logic [3:0]  wait_q;
  logic [11:0] rom_addr_q;
  logic        rom_n_oe_q;
  logic [11:0] bs_addr_q;
  logic [7:0]  bs_data_q;
  logic        bs_n_we_q;
  logic        n_booted_q;
  logic        sys_n_rst_q;
`ifdef BOOTSTRAP_CHECKSUM_EN
  logic [7:0]  sum_q;
  logic        checking_q;   // set while reading the check byte
  logic        boot_err_q;
`endif

  // idx never wraps: HOLD of idx==LAST_IDX leaves the copy loop before the
  // increment is used, except for the check-byte read where COUNT <= 4095.
  assign idx_d = idx_q + 12'd1;

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values of the others, as real flops do.
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      wait_q      <= '0;
      rom_addr_q  <= '0;
      rom_n_oe_q  <= 1'b1;
      bs_addr_q   <= '0;
      bs_data_q   <= '0;
      bs_n_we_q   <= 1'b1;
      n_booted_q  <= 1'b1;
      sys_n_rst_q <= 1'b0;
`ifdef BOOTSTRAP_CHECKSUM_EN
      sum_q       <= '0;
      checking_q  <= 1'b0;
      boot_err_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_LOAD: begin
          // Every LOAD entered from HOLD already has the address presented and
          // the ROM enabled; only the LOAD straight after reset must set them.
          if (rom_n_oe_q) begin
            rom_addr_q <= idx_q;
            rom_n_oe_q <= 1'b0;
          end else begin
            wait_q  <= WAIT_LOAD;
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          wait_q <= wait_q - 4'd1;
          // Exit on the edge that takes the counter to zero: ROM_DATA is
          // sampled here and nowhere else.
          if (wait_q == 4'd1) begin
            rom_n_oe_q <= 1'b1;
`ifdef BOOTSTRAP_CHECKSUM_EN
            sum_q      <= sum_q + ROM_DATA;
            if (checking_q) begin
              state_q <= S_CHECK;
            end else begin
              bs_data_q <= ROM_DATA;
              bs_addr_q <= idx_q;
              bs_n_we_q <= 1'b0;
              state_q   <= S_WRITE;
            end
`else
            bs_data_q  <= ROM_DATA;
            bs_addr_q  <= idx_q;
            bs_n_we_q  <= 1'b0;
            state_q    <= S_WRITE;
`endif
          end
        end

        S_WRITE: begin
          // The store latches on this rising strobe edge; address and data
          // stay put through HOLD.
          bs_n_we_q <= 1'b1;
          state_q   <= S_HOLD;
        end

        S_HOLD: begin
          if (idx_q == LAST_IDX) begin
`ifdef BOOTSTRAP_CHECKSUM_EN
            // Reuse the LOAD/WAIT read path for the check byte at COUNT.
            checking_q <= 1'b1;
            idx_q      <= idx_d;
            rom_addr_q <= idx_d;
            rom_n_oe_q <= 1'b0;
            state_q    <= S_LOAD;
`else
            n_booted_q <= 1'b0;
            state_q    <= S_DONE;
`endif
          end else begin
            idx_q      <= idx_d;
            rom_addr_q <= idx_d;
            rom_n_oe_q <= 1'b0;
            state_q    <= S_LOAD;
          end
        end

`ifdef BOOTSTRAP_CHECKSUM_EN
        S_CHECK: begin
          // sum_q already includes the check byte.
          if (sum_q == 8'd0) begin
            n_booted_q <= 1'b0;
            state_q    <= S_DONE;
          end else begin
            boot_err_q <= 1'b1;
            state_q    <= S_ERROR;
          end
        end

        S_ERROR: begin
          state_q <= S_ERROR;
        end
`endif

        S_DONE: begin
          // Release the CPU one cycle after the store switches to read mode.
          if (!n_booted_q) sys_n_rst_q <= 1'b1;
        end

        default: begin
          state_q <= S_LOAD;
        end
      endcase
    end
  end

  assign ROM_ADDR       = rom_addr_q;
  assign ROM_N_OE       = rom_n_oe_q;
  assign BOOTSTRAP_ADDR = bs_addr_q;
  assign BOOTSTRAP_DATA = bs_data_q;
  assign BOOTSTRAP_N_WE = bs_n_we_q;
  assign N_BOOTED       = n_booted_q;
  assign SYS_N_RST      = sys_n_rst_q;
`ifdef BOOTSTRAP_CHECKSUM_EN
  assign BOOT_ERR       = boot_err_q;
`else
  assign BOOT_ERR       = 1'b0;
`endif

endmodule

// File: tb/tb_microcode_bootstrap.sv
// -----------------------------------------------------------------------------
// tb_microcode_bootstrap
//
// Directed bench for microcode_bootstrap. Instances:
//   A : COUNT=4,    ROM_WAIT=2, ROM 11,22,33,44 (also used for mid-load reset)
//   B : COUNT=2,    ROM_WAIT=1
//   C : COUNT=4096, ROM_WAIT=2
//   D/E (only with BOOTSTRAP_CHECKSUM_EN): COUNT=2, bytes 10,20, check D0 / D1
// Event times are counted in rising edges after the reset release.
// -----------------------------------------------------------------------------
module tb_microcode_bootstrap;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- ROM images ----------------
  function automatic logic [7:0] rom_a(input logic [11:0] a);
    case (a)
      12'd0:   rom_a = 8'h11;
      12'd1:   rom_a = 8'h22;
      12'd2:   rom_a = 8'h33;
      12'd3:   rom_a = 8'h44;
      default: rom_a = 8'hEE;
    endcase
  endfunction

  function automatic logic [7:0] rom_b(input logic [11:0] a);
    rom_b = (a == 12'd0) ? 8'h5A : (a == 12'd1) ? 8'hA5 : 8'hEE;
  endfunction

  function automatic logic [7:0] rom_c(input logic [11:0] a);
    rom_c = a[7:0] ^ a[11:4];
  endfunction

  // ---------------- instance A ----------------
  logic        rst_a = 1'b0;
  logic [11:0] a_rom_addr, a_bs_addr;
  logic [7:0]  a_rom_data, a_bs_data;
  logic        a_rom_n_oe, a_n_we, a_n_booted, a_sys, a_err;
  assign a_rom_data = rom_a(a_rom_addr);

  microcode_bootstrap #(.COUNT(4), .ROM_WAIT(2)) u_a (
    .CLK(clk), .N_RST(rst_a), .ROM_ADDR(a_rom_addr), .ROM_N_OE(a_rom_n_oe),
    .ROM_DATA(a_rom_data), .BOOTSTRAP_ADDR(a_bs_addr), .BOOTSTRAP_DATA(a_bs_data),
    .BOOTSTRAP_N_WE(a_n_we), .N_BOOTED(a_n_booted), .SYS_N_RST(a_sys), .BOOT_ERR(a_err));

  int          rel0_a = 0;
  int          nw_a = 0, nb_a = -1, sysr_a = -1, oe_a = 0, inv_a = 0;
  int          wr_rel_a [8];
  logic [11:0] wr_addr_a [8];
  logic [7:0]  wr_data_a [8];

  always @(negedge clk) begin
    if (!rst_a) begin
      nw_a <= 0; nb_a <= -1; sysr_a <= -1; oe_a <= 0; inv_a <= 0;
    end else begin
      if (!a_n_we) begin
        if (nw_a < 8) begin
          wr_rel_a[nw_a[2:0]]  <= cyc - rel0_a;
          wr_addr_a[nw_a[2:0]] <= a_bs_addr;
          wr_data_a[nw_a[2:0]] <= a_bs_data;
        end
        nw_a <= nw_a + 1;
      end
      if (!a_n_booted && nb_a < 0) nb_a <= cyc - rel0_a;
      if (a_sys && sysr_a < 0)     sysr_a <= cyc - rel0_a;
      if (!a_rom_n_oe)             oe_a <= oe_a + 1;
      if (!a_n_we && !a_n_booted)  inv_a <= inv_a + 1;
    end
  end

  // ---------------- instance B ----------------
  logic        rst_b = 1'b0;
  logic [11:0] b_rom_addr, b_bs_addr;
  logic [7:0]  b_rom_data, b_bs_data;
  logic        b_rom_n_oe, b_n_we, b_n_booted, b_sys, b_err;
  assign b_rom_data = rom_b(b_rom_addr);

  microcode_bootstrap #(.COUNT(2), .ROM_WAIT(1)) u_b (
    .CLK(clk), .N_RST(rst_b), .ROM_ADDR(b_rom_addr), .ROM_N_OE(b_rom_n_oe),
    .ROM_DATA(b_rom_data), .BOOTSTRAP_ADDR(b_bs_addr), .BOOTSTRAP_DATA(b_bs_data),
    .BOOTSTRAP_N_WE(b_n_we), .N_BOOTED(b_n_booted), .SYS_N_RST(b_sys), .BOOT_ERR(b_err));

  int          rel0 = 0;
  int          nw_b = 0, nb_b = -1, sysr_b = -1, oe_b = 0, inv_b = 0;
  int          wr_rel_b [4];
  logic [11:0] wr_addr_b [4];
  logic [7:0]  wr_data_b [4];

  always @(negedge clk) begin
    if (rst_b) begin
      if (!b_n_we) begin
        if (nw_b < 4) begin
          wr_rel_b[nw_b[1:0]]  <= cyc - rel0;
          wr_addr_b[nw_b[1:0]] <= b_bs_addr;
          wr_data_b[nw_b[1:0]] <= b_bs_data;
        end
        nw_b <= nw_b + 1;
      end
      if (!b_n_booted && nb_b < 0) nb_b <= cyc - rel0;
      if (b_sys && sysr_b < 0)     sysr_b <= cyc - rel0;
      if (!b_rom_n_oe)             oe_b <= oe_b + 1;
      if (!b_n_we && !b_n_booted)  inv_b <= inv_b + 1;
    end
  end

  // ---------------- instance C ----------------
  logic        rst_c = 1'b0;
  logic [11:0] c_rom_addr, c_bs_addr;
  logic [7:0]  c_rom_data, c_bs_data;
  logic        c_rom_n_oe, c_n_we, c_n_booted, c_sys, c_err;
  assign c_rom_data = rom_c(c_rom_addr);

  microcode_bootstrap #(.COUNT(4096), .ROM_WAIT(2)) u_c (
    .CLK(clk), .N_RST(rst_c), .ROM_ADDR(c_rom_addr), .ROM_N_OE(c_rom_n_oe),
    .ROM_DATA(c_rom_data), .BOOTSTRAP_ADDR(c_bs_addr), .BOOTSTRAP_DATA(c_bs_data),
    .BOOTSTRAP_N_WE(c_n_we), .N_BOOTED(c_n_booted), .SYS_N_RST(c_sys), .BOOT_ERR(c_err));

  int          nw_c = 0, ord_c = 0, nb_c = -1, sysr_c = -1, inv_c = 0;
  logic [11:0] last_c = '0;

  always @(negedge clk) begin
    if (rst_c) begin
      if (!c_n_we) begin
        if (c_bs_addr !== nw_c[11:0] || c_bs_data !== rom_c(c_bs_addr)) ord_c <= ord_c + 1;
        last_c <= c_bs_addr;
        nw_c   <= nw_c + 1;
      end
      if (!c_n_booted && nb_c < 0) nb_c <= cyc - rel0;
      if (c_sys && sysr_c < 0)     sysr_c <= cyc - rel0;
      if (!c_n_we && !c_n_booted)  inv_c <= inv_c + 1;
    end
  end

`ifdef BOOTSTRAP_CHECKSUM_EN
  // ---------------- instances D (good check byte) / E (bad) ----------------
  logic        rst_d = 1'b0;
  logic [11:0] d_rom_addr, d_bs_addr, e_rom_addr, e_bs_addr;
  logic [7:0]  d_rom_data, d_bs_data, e_rom_data, e_bs_data;
  logic        d_rom_n_oe, d_n_we, d_n_booted, d_sys, d_err;
  logic        e_rom_n_oe, e_n_we, e_n_booted, e_sys, e_err;
  assign d_rom_data = (d_rom_addr == 12'd0) ? 8'h10 : (d_rom_addr == 12'd1) ? 8'h20 :
                      (d_rom_addr == 12'd2) ? 8'hD0 : 8'hEE;
  assign e_rom_data = (e_rom_addr == 12'd0) ? 8'h10 : (e_rom_addr == 12'd1) ? 8'h20 :
                      (e_rom_addr == 12'd2) ? 8'hD1 : 8'hEE;

  microcode_bootstrap #(.COUNT(2), .ROM_WAIT(2)) u_d (
    .CLK(clk), .N_RST(rst_d), .ROM_ADDR(d_rom_addr), .ROM_N_OE(d_rom_n_oe),
    .ROM_DATA(d_rom_data), .BOOTSTRAP_ADDR(d_bs_addr), .BOOTSTRAP_DATA(d_bs_data),
    .BOOTSTRAP_N_WE(d_n_we), .N_BOOTED(d_n_booted), .SYS_N_RST(d_sys), .BOOT_ERR(d_err));

  microcode_bootstrap #(.COUNT(2), .ROM_WAIT(2)) u_e (
    .CLK(clk), .N_RST(rst_d), .ROM_ADDR(e_rom_addr), .ROM_N_OE(e_rom_n_oe),
    .ROM_DATA(e_rom_data), .BOOTSTRAP_ADDR(e_bs_addr), .BOOTSTRAP_DATA(e_bs_data),
    .BOOTSTRAP_N_WE(e_n_we), .N_BOOTED(e_n_booted), .SYS_N_RST(e_sys), .BOOT_ERR(e_err));

  int nb_d = -1, sysr_d = -1, nw_d = 0, nw_e = 0, e_sys_seen = 0, inv_de = 0;

  always @(negedge clk) begin
    if (rst_d) begin
      if (!d_n_booted && nb_d < 0) nb_d <= cyc - rel0;
      if (d_sys && sysr_d < 0)     sysr_d <= cyc - rel0;
      if (!d_n_we)                 nw_d <= nw_d + 1;
      if (!e_n_we)                 nw_e <= nw_e + 1;
      if (e_sys || !e_n_booted)    e_sys_seen <= e_sys_seen + 1;
      if ((!d_n_we && !d_n_booted) || (!e_n_we && !e_n_booted)) inv_de <= inv_de + 1;
    end
  end
`endif

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    #1;
    // Reset state, before any clock edge with reset released.
    check("rst_rom_n_oe",   32'(a_rom_n_oe), 32'd1);
    check("rst_n_we",       32'(a_n_we),     32'd1);
    check("rst_n_booted",   32'(a_n_booted), 32'd1);
    check("rst_sys_n_rst",  32'(a_sys),      32'd0);
    check("rst_boot_err",   32'(a_err),      32'd0);

    #1;
    rel0   = cyc;
    rel0_a = cyc;
    rst_a  = 1'b1;
    rst_b  = 1'b1;
    rst_c  = 1'b1;
`ifdef BOOTSTRAP_CHECKSUM_EN
    rst_d  = 1'b1;
`endif

    repeat (30) @(negedge clk);
    #1;

    // A: four single-cycle pulses, 5 cycles apart, addresses 0..3.
    check("a_write_count", 32'(nw_a), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("a_wr%0d_cycle", i), 32'(wr_rel_a[i]), 32'(4 + 5 * i));
      check($sformatf("a_wr%0d_addr",  i), 32'(wr_addr_a[i]), 32'(i));
    end
    check("a_wr0_data", 32'(wr_data_a[0]), 32'h11);
    check("a_wr1_data", 32'(wr_data_a[1]), 32'h22);
    check("a_wr2_data", 32'(wr_data_a[2]), 32'h33);
    check("a_wr3_data", 32'(wr_data_a[3]), 32'h44);
    check("a_n_booted_fall", 32'(nb_a),   32'd21);
    check("a_sys_rise",      32'(sysr_a), 32'd22);
    check("a_oe_low_cycles", 32'(oe_a),   32'd12);
    check("a_invariant",     32'(inv_a),  32'd0);
    check("a_boot_err",      32'(a_err),  32'd0);

    // B: ROM_WAIT=1, pulses 4 apart, ROM_N_OE low 2 cycles per byte.
    check("b_write_count",   32'(nw_b),         32'd2);
    check("b_wr0_cycle",     32'(wr_rel_b[0]),  32'd3);
    check("b_wr1_cycle",     32'(wr_rel_b[1]),  32'd7);
    check("b_wr0_addr",      32'(wr_addr_b[0]), 32'd0);
    check("b_wr1_addr",      32'(wr_addr_b[1]), 32'd1);
    check("b_wr0_data",      32'(wr_data_b[0]), 32'h5A);
    check("b_wr1_data",      32'(wr_data_b[1]), 32'hA5);
    check("b_oe_low_cycles", 32'(oe_b),         32'd4);
    check("b_n_booted_fall", 32'(nb_b),         32'd9);
    check("b_sys_rise",      32'(sysr_b),       32'd10);
    check("b_invariant",     32'(inv_b),        32'd0);

`ifdef BOOTSTRAP_CHECKSUM_EN
    // D: 10+20+D0 = 0 mod 256 -> DONE. E: check byte D1 -> ERROR.
    check("d_write_count",   32'(nw_d),       32'd2);
    check("d_n_booted_fall", 32'(nb_d),       32'd15);
    check("d_sys_rise",      32'(sysr_d),     32'd16);
    check("d_boot_err",      32'(d_err),      32'd0);
    check("e_write_count",   32'(nw_e),       32'd2);
    check("e_boot_err",      32'(e_err),      32'd1);
    check("e_n_booted",      32'(e_n_booted), 32'd1);
    check("e_sys_n_rst",     32'(e_sys),      32'd0);
`endif

    // A: reset during the third byte's WAIT, then restart from address 0.
    rst_a = 1'b0;
    @(negedge clk);
    #1;
    rel0_a = cyc;
    rst_a  = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    check("a_mid_wait_oe",   32'(a_rom_n_oe), 32'd0);
    check("a_mid_wait_addr", 32'(a_rom_addr), 32'd2);
    check("a_mid_bs_addr",   32'(a_bs_addr),  32'd1);
    rst_a = 1'b0;
    #1;
    check("a_arst_rom_addr", 32'(a_rom_addr), 32'd0);
    check("a_arst_rom_n_oe", 32'(a_rom_n_oe), 32'd1);
    check("a_arst_bs_addr",  32'(a_bs_addr),  32'd0);
    check("a_arst_bs_data",  32'(a_bs_data),  32'd0);
    check("a_arst_n_we",     32'(a_n_we),     32'd1);
    check("a_arst_n_booted", 32'(a_n_booted), 32'd1);
    check("a_arst_sys",      32'(a_sys),      32'd0);
    check("a_arst_err",      32'(a_err),      32'd0);
    @(negedge clk);
    #1;
    rel0_a = cyc;
    rst_a  = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("a_restart_count", 32'(nw_a),         32'd1);
    check("a_restart_cycle", 32'(wr_rel_a[0]),  32'd4);
    check("a_restart_addr",  32'(wr_addr_a[0]), 32'd0);
    check("a_restart_data",  32'(wr_data_a[0]), 32'h11);

    // C: COUNT=4096 boundary. Bounded wait well past the expected finish.
    repeat (20600) @(negedge clk);
    #1;
    check("c_write_count",   32'(nw_c),   32'd4096);
    check("c_last_addr",     32'(last_c), 32'hFFF);
    check("c_order_errors",  32'(ord_c),  32'd0);
    check("c_n_booted_fall", 32'(nb_c),   32'd20481);
    check("c_sys_rise",      32'(sysr_c), 32'd20482);
    check("c_invariant",     32'(inv_c),  32'd0);
    check("a_invariant_end", 32'(inv_a),  32'd0);
    check("a_rerun_count",   32'(nw_a),   32'd4);
`ifdef BOOTSTRAP_CHECKSUM_EN
    check("e_never_booted",  32'(e_sys_seen), 32'd0);
    check("e_boot_err_hold", 32'(e_err),      32'd1);
    check("de_invariant",    32'(inv_de),     32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
